alarm_clock_multi: RTL and testbench
====================================

# alarm_clock_multi

Parametrised successor to the lab-2 clock/alarm top level. It contains:
- a seconds/minutes/hours/days time chain;
- NA independently armed alarm channels, each with its own set registers;
- a per-channel ring/snooze state machine with automatic ring timeout;
- "every day" alarm matching.

It sits between the front-panel buttons and the lcd_int display drivers, and drives the Buzz output. All values are binary; 7-segment decode stays outside this block.

## Interface
- NS, 60: seconds/minutes modulus (2..127)
- NH, 24: hours modulus (2..127)
- ND, 7: days modulus (2..126); alarm day value ND means "every day"
- NA, 2: number of alarm channels (2..8)
- RING_MAX, 60: ring duration in Pulse cycles before auto-stop (1..65535)
- SNZ_SEC, 300: snooze duration in Pulse cycles (1..65535)

Ports:
- Pulse  in  1  clock, one cycle per second
- Reset  in  1  synchronous, active-high reset
- Timeset  in  1  time-set mode; seconds hold, advance buttons act on time
- Alarmset  in  1  alarm-set mode; advance buttons act on channel Alsel
- Alsel  in  $clog2(NA)  alarm channel selected for setting/display
- Minadv, Hrsadv, Dayadv  in  1 each  advance buttons, sampled every cycle
- Alarmon  in  NA  per-channel arm
- Snooze  in  1  snooze all ringing channels
- Ack  in  1  stop all ringing/snoozed channels
- TSec, TMin, THrs, TDays  out  7 each  current time
- DMin, DHrs, DDays  out  7 each  display mux: alarm Alsel when Alarmset, else time
- Ringing  out  NA  channel i in RING state
- Buzz  out  1  OR of Ringing

## Operation

**Time chain**
- Seconds: +1 per cycle when !Timeset; NS-1 wraps to 0.
- Minutes: +1 when (!Timeset && TSec==NS-1), or when (Timeset && Minadv).
- Hours: +1 when (!Timeset && TSec==NS-1 && TMin==NS-1), or when (Timeset && Hrsadv).
- Days: same rule one level up (all lower counters at max), or when (Timeset && Dayadv). Wraps ND-1 to 0.
- Manual advances never carry: minute 59 advanced to 0 leaves hours unchanged.
- Timeset takes priority over Alarmset. When both are high, advance buttons act on time only.

**Alarm set registers** (per channel i)
- AMin[i] advances when Alarmset && !Timeset && Alsel==i && Minadv, modulus NS.
- AHrs[i] and ADays[i] advance the same way with Hrsadv/Dayadv; AHrs modulus NH, ADays modulus ND+1.
- If Alsel ≥ NA, no register advances and the display shows time.

**Match[i]** (combinational, current-cycle values) is true when all of these hold:
- Alarmon[i] and !Timeset;
- TSec==0, TMin==AMin[i], THrs==AHrs[i];
- ADays[i]==ND or TDays==ADays[i].

**Channel FSM** (states IDLE, RING, SNZ)
- Event priority: Reset > !Alarmon[i] > Ack > Snooze > Match[i] > timer.
- Any state with !Alarmon[i] → IDLE.
- IDLE: on Match → RING, ring counter loaded RING_MAX-1.
- RING:
  - Ack → IDLE.
  - Snooze → SNZ, snooze counter loaded SNZ_SEC-1.
  - Match → RING with ring counter reloaded.
  - Else ring counter==0 → IDLE.
  - Else ring counter decrements.
- SNZ:
  - Ack → IDLE.
  - Snooze: no effect.
  - Match → RING (reload).
  - Else snooze counter==0 → RING (reload).
  - Else snooze counter decrements.
- Snooze/Ack in IDLE: no effect.
- Each channel has its own counters.

## Timing
- Every register updates on the rising edge of Pulse. Outputs are register values or direct decodes of them, so there are no combinational input-to-output paths. The one exception is the D* mux, which is combinational from Alarmset/Alsel.
- Reset (synchronous), all values 0: TSec, TMin, THrs, TDays, all alarm registers, all counters, Ringing, Buzz.
- Reset takes priority over every input in the same cycle, including mid-ring.
- All FSM states reset to IDLE.
- Match evaluated in the cycle TSec==0 → Ringing[i] high in the cycle TSec==1.
- Ringing stays high exactly RING_MAX cycles when undisturbed.
- Snooze asserted in cycle k → Ringing low from k+1 for exactly SNZ_SEC cycles, then high.
- Buzz is always equal to |Ringing in the same cycle.
- Multiple channels may ring at once. Snooze/Ack act on all channels simultaneously.
- Timeset held through the match second suppresses the alarm; it is not deferred.

## Test plan
1. **Wrap.** Reset, then advance time to day 6, 23:59:59. After one Pulse: TDays=0, THrs=0, TMin=0, TSec=0, Buzz=0.
2. **Every-day match, channel 1.** Alsel=1, Alarmset; set AMin=2, AHrs=0, ADays=7. Alarmon=2'b10; run from reset with Timeset=0. Ringing=2'b10 at TMin=2, TSec=1, for exactly 60 cycles, then 2'b00. Channel 0 (alarm 00:00, Alarmon[0]=0) never rings.
3. **Snooze.** Snooze pulse on the 5th ringing cycle → Ringing low for 300 cycles, then high again for 60. Ack during SNZ → IDLE, no further ring.
4. **Day-specific miss.** ADays=3 with TDays=2 at the matching minute → no ring. The same setting at TDays=3 rings.
5. **Manual set.** Timeset=1 with Minadv held 61 cycles from 00:00 → TMin=1, THrs=0 (no carry), TSec frozen. A match second during Timeset produces no ring.
6. **Disarm/reset precedence.** While ringing: Alarmon[1]=0 → Ringing=0 next cycle. Re-ring, then Reset plus Snooze in the same cycle → all outputs 0, all alarm registers 0.

Source files
------------

// File: rtl/alarm_clock_multi_if.sv
// Front-panel inputs and display/buzzer outputs of the multi-alarm clock.
interface alarm_clock_multi_if #(
    parameter int unsigned NA = 2
);
    localparam int unsigned AW = (NA > 1) ? $clog2(NA) : 1;

    logic          timeset;
    logic          alarmset;
    logic [AW-1:0] alsel;
    logic          minadv;
    logic          hrsadv;
    logic          dayadv;
    logic [NA-1:0] alarmon;
    logic          snooze;
    logic          ack;

    logic [6:0]    tsec;
    logic [6:0]    tmin;
    logic [6:0]    thrs;
    logic [6:0]    tdays;
    logic [6:0]    dmin;
    logic [6:0]    dhrs;
    logic [6:0]    ddays;
    logic [NA-1:0] ringing;
    logic          buzz;

    modport master (
        output timeset, alarmset, alsel, minadv, hrsadv, dayadv, alarmon, snooze, ack,
        input  tsec, tmin, thrs, tdays, dmin, dhrs, ddays, ringing, buzz
    );

    modport slave (
        input  timeset, alarmset, alsel, minadv, hrsadv, dayadv, alarmon, snooze, ack,
        output tsec, tmin, thrs, tdays, dmin, dhrs, ddays, ringing, buzz
    );
endinterface

// File: rtl/alarm_clock_multi.sv
// Time-of-day/day-of-week clock with NA independent alarm channels, each with
// its own ring/snooze state machine and ring timeout. Clocked once per second.
module alarm_clock_multi #(
    parameter int unsigned NS       = 60,
    parameter int unsigned NH       = 24,
    parameter int unsigned ND       = 7,
    parameter int unsigned NA       = 2,
    parameter int unsigned RING_MAX = 60,
    parameter int unsigned SNZ_SEC  = 300
) (
    input logic                pulse,
    input logic                reset,
    alarm_clock_multi_if.slave bus
);
    localparam int unsigned AW = (NA > 1) ? $clog2(NA) : 1;
    localparam logic [15:0] RING_LOAD = 16'(RING_MAX - 1);
    localparam logic [15:0] SNZ_LOAD  = 16'(SNZ_SEC - 1);

    typedef enum logic [1:0] {StIdle, StRing, StSnz} ch_state_e;

    logic [6:0]    tsec_q, tmin_q, thrs_q, tdays_q;
    logic [6:0]    amin_q  [NA];
    logic [6:0]    ahrs_q  [NA];
    logic [6:0]    adays_q [NA];
    ch_state_e     state_q [NA];
    ch_state_e     state_d [NA];
    logic [15:0]   ring_cnt_q [NA];
    logic [15:0]   ring_cnt_d [NA];
    logic [15:0]   snz_cnt_q  [NA];
    logic [15:0]   snz_cnt_d  [NA];
    logic [NA-1:0] match;
    logic [NA-1:0] sel_onehot;
    logic [NA-1:0] ringing;
    logic          sec_wrap, min_wrap, hrs_wrap, day_wrap;
    logic          min_inc, hrs_inc, day_inc;

    // Carry conditions; manual advances replace the carry chain and never ripple.
    always_comb begin
        sec_wrap = (tsec_q == 7'(NS - 1));
        min_wrap = (tmin_q == 7'(NS - 1));
        hrs_wrap = (thrs_q == 7'(NH - 1));
        day_wrap = (tdays_q == 7'(ND - 1));
        min_inc  = bus.timeset ? bus.minadv : sec_wrap;
        hrs_inc  = bus.timeset ? bus.hrsadv : (sec_wrap && min_wrap);
        day_inc  = bus.timeset ? bus.dayadv : (sec_wrap && min_wrap && hrs_wrap);
    end

    // Time chain registers.
    always_ff @(posedge pulse) begin
        if (reset) begin
            tsec_q  <= '0;
            tmin_q  <= '0;
            thrs_q  <= '0;
            tdays_q <= '0;
        end else begin
            if (!bus.timeset) tsec_q  <= sec_wrap ? '0 : tsec_q + 7'd1;
            if (min_inc)      tmin_q  <= min_wrap ? '0 : tmin_q + 7'd1;
            if (hrs_inc)      thrs_q  <= hrs_wrap ? '0 : thrs_q + 7'd1;
            if (day_inc)      tdays_q <= day_wrap ? '0 : tdays_q + 7'd1;
        end
    end

    // Channel select decode; an out-of-range alsel selects nothing.
    always_comb begin
        sel_onehot = '0;
        for (int unsigned i = 0; i < NA; i++) begin
            sel_onehot[i] = (bus.alsel == AW'(i));
        end
    end

    // Alarm set registers; time-set mode locks them out.
    always_ff @(posedge pulse) begin
        for (int unsigned i = 0; i < NA; i++) begin
            if (reset) begin
                amin_q[i]  <= '0;
                ahrs_q[i]  <= '0;
                adays_q[i] <= '0;
            end else if (bus.alarmset && !bus.timeset && sel_onehot[i]) begin
                if (bus.minadv) amin_q[i]  <= (amin_q[i] == 7'(NS - 1)) ? '0 : amin_q[i] + 7'd1;
                if (bus.hrsadv) ahrs_q[i]  <= (ahrs_q[i] == 7'(NH - 1)) ? '0 : ahrs_q[i] + 7'd1;
                // ADays counts 0..ND, where ND is the every-day setting.
                if (bus.dayadv) adays_q[i] <= (adays_q[i] == 7'(ND)) ? '0 : adays_q[i] + 7'd1;
            end
        end
    end

    // Per-channel alarm match on the current second.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < NA; i++) begin
            match[i] = bus.alarmon[i] && !bus.timeset && (tsec_q == '0) &&
                       (tmin_q == amin_q[i]) && (thrs_q == ahrs_q[i]) &&
                       ((adays_q[i] == 7'(ND)) || (tdays_q == adays_q[i]));
        end
    end

    // Channel state and counter registers.
    always_ff @(posedge pulse) begin
        for (int unsigned i = 0; i < NA; i++) begin
            if (reset) begin
                state_q[i]    <= StIdle;
                ring_cnt_q[i] <= '0;
                snz_cnt_q[i]  <= '0;
            end else begin
                state_q[i]    <= state_d[i];
                ring_cnt_q[i] <= ring_cnt_d[i];
                snz_cnt_q[i]  <= snz_cnt_d[i];
            end
        end
    end

    // Channel next state: disarm > ack > snooze > match > timer.
    always_comb begin
        for (int unsigned i = 0; i < NA; i++) begin
            state_d[i]    = state_q[i];
            ring_cnt_d[i] = ring_cnt_q[i];
            snz_cnt_d[i]  = snz_cnt_q[i];
            if (!bus.alarmon[i]) begin
                state_d[i] = StIdle;
            end else begin
                case (state_q[i])
                    StIdle: begin
                        if (match[i]) begin
                            state_d[i]    = StRing;
                            ring_cnt_d[i] = RING_LOAD;
                        end
                    end
                    StRing: begin
                        if (bus.ack) begin
                            state_d[i] = StIdle;
                        end else if (bus.snooze) begin
                            state_d[i]   = StSnz;
                            snz_cnt_d[i] = SNZ_LOAD;
                        end else if (match[i]) begin
                            ring_cnt_d[i] = RING_LOAD;
                        end else if (ring_cnt_q[i] == '0) begin
                            state_d[i] = StIdle;
                        end else begin
                            ring_cnt_d[i] = ring_cnt_q[i] - 16'd1;
                        end
                    end
                    StSnz: begin
                        // Snooze while already snoozing is ignored.
                        if (bus.ack) begin
                            state_d[i] = StIdle;
                        end else if (match[i] || (snz_cnt_q[i] == '0)) begin
                            state_d[i]    = StRing;
                            ring_cnt_d[i] = RING_LOAD;
                        end else begin
                            snz_cnt_d[i] = snz_cnt_q[i] - 16'd1;
                        end
                    end
                    default: state_d[i] = StIdle;
                endcase
            end
        end
    end

    // Outputs: state decodes plus the alarm/time display mux.
    always_comb begin
        ringing   = '0;
        bus.dmin  = tmin_q;
        bus.dhrs  = thrs_q;
        bus.ddays = tdays_q;
        for (int unsigned i = 0; i < NA; i++) begin
            ringing[i] = (state_q[i] == StRing);
            if (bus.alarmset && sel_onehot[i]) begin
                bus.dmin  = amin_q[i];
                bus.dhrs  = ahrs_q[i];
                bus.ddays = adays_q[i];
            end
        end
        bus.ringing = ringing;
        bus.buzz    = |ringing;
        bus.tsec    = tsec_q;
        bus.tmin    = tmin_q;
        bus.thrs    = thrs_q;
        bus.tdays   = tdays_q;
    end
endmodule

// File: tb/tb_alarm_clock_multi.sv
// Bench for alarm_clock_multi: directed scenarios plus random stimulus, all
// outputs compared every cycle against a seconds-count behavioural model.
module tb_alarm_clock_multi;
    localparam int NS       = 60;
    localparam int NH       = 24;
    localparam int ND       = 7;
    localparam int NA       = 2;
    localparam int RING_MAX = 60;
    localparam int SNZ_SEC  = 300;

    logic pulse = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    alarm_clock_multi_if #(.NA(NA)) bus();

    alarm_clock_multi #(
        .NS(NS), .NH(NH), .ND(ND), .NA(NA), .RING_MAX(RING_MAX), .SNZ_SEC(SNZ_SEC)
    ) dut (
        .pulse(pulse),
        .reset(reset),
        .bus  (bus)
    );

    always #5 pulse = ~pulse;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ring_left = ringing seconds still to go (0 = not ringing),
    // snz_left = silent seconds still to go (0 = not snoozing).
    int m_sec, m_min, m_hrs, m_day;
    int m_amin [NA];
    int m_ahrs [NA];
    int m_aday [NA];
    int ring_left [NA];
    int snz_left  [NA];
    bit m_valid = 1'b0;

    always @(posedge pulse) begin : model_step
        bit hit [NA];
        int v, c, k;
        if (reset) begin
            m_sec = 0; m_min = 0; m_hrs = 0; m_day = 0;
            for (int i = 0; i < NA; i++) begin
                m_amin[i] = 0; m_ahrs[i] = 0; m_aday[i] = 0;
                ring_left[i] = 0; snz_left[i] = 0;
            end
            m_valid = 1'b1;
        end else if (m_valid) begin
            for (int i = 0; i < NA; i++) begin
                hit[i] = bus.alarmon[i] && !bus.timeset && m_sec == 0 && m_min == m_amin[i] &&
                         m_hrs == m_ahrs[i] && (m_aday[i] == ND || m_day == m_aday[i]);
            end
            for (int i = 0; i < NA; i++) begin
                if (!bus.alarmon[i]) begin
                    ring_left[i] = 0;
                    snz_left[i]  = 0;
                end else if (ring_left[i] > 0) begin
                    if (bus.ack) ring_left[i] = 0;
                    else if (bus.snooze) begin
                        ring_left[i] = 0;
                        snz_left[i]  = SNZ_SEC;
                    end else if (hit[i]) ring_left[i] = RING_MAX;
                    else ring_left[i] = ring_left[i] - 1;
                end else if (snz_left[i] > 0) begin
                    if (bus.ack) snz_left[i] = 0;
                    else if (hit[i] || snz_left[i] == 1) begin
                        snz_left[i]  = 0;
                        ring_left[i] = RING_MAX;
                    end else snz_left[i] = snz_left[i] - 1;
                end else if (hit[i]) begin
                    ring_left[i] = RING_MAX;
                end
            end
            if (bus.alarmset && !bus.timeset && int'(bus.alsel) < NA) begin
                k = int'(bus.alsel);
                if (bus.minadv) m_amin[k] = (m_amin[k] + 1) % NS;
                if (bus.hrsadv) m_ahrs[k] = (m_ahrs[k] + 1) % NH;
                if (bus.dayadv) m_aday[k] = (m_aday[k] + 1) % (ND + 1);
            end
            if (!bus.timeset) begin
                v = m_sec + 1; m_sec = v % NS; c = v / NS;
                v = m_min + c; m_min = v % NS; c = v / NS;
                v = m_hrs + c; m_hrs = v % NH; c = v / NH;
                m_day = (m_day + c) % ND;
            end else begin
                if (bus.minadv) m_min = (m_min + 1) % NS;
                if (bus.hrsadv) m_hrs = (m_hrs + 1) % NH;
                if (bus.dayadv) m_day = (m_day + 1) % ND;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge pulse) begin : compare
        logic [NA-1:0] exp_ring;
        bit show_alarm;
        int k;
        if (m_valid) begin
            for (int i = 0; i < NA; i++) exp_ring[i] = ring_left[i] > 0;
            show_alarm = bus.alarmset && int'(bus.alsel) < NA;
            k = show_alarm ? int'(bus.alsel) : 0;
            chk("tsec", 32'(bus.tsec), m_sec);
            chk("tmin", 32'(bus.tmin), m_min);
            chk("thrs", 32'(bus.thrs), m_hrs);
            chk("tdays", 32'(bus.tdays), m_day);
            chk("dmin", 32'(bus.dmin), show_alarm ? m_amin[k] : m_min);
            chk("dhrs", 32'(bus.dhrs), show_alarm ? m_ahrs[k] : m_hrs);
            chk("ddays", 32'(bus.ddays), show_alarm ? m_aday[k] : m_day);
            chk("ringing", 32'(bus.ringing), 32'(exp_ring));
            chk("buzz", 32'(bus.buzz), 32'(exp_ring != '0));
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(posedge pulse);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(1);
        reset = 1'b0;
    endtask

    task automatic set_btn(input int which, input logic val);
        case (which)
            0: bus.minadv = val;
            1: bus.hrsadv = val;
            default: bus.dayadv = val;
        endcase
    endtask

    task automatic tpress(input int which, input int n);
        bus.timeset = 1'b1;
        set_btn(which, 1'b1);
        run(n);
        set_btn(which, 1'b0);
        bus.timeset = 1'b0;
    endtask

    task automatic apress(input int ch, input int which, input int n);
        bus.alarmset = 1'b1;
        bus.alsel    = ch[0];
        set_btn(which, 1'b1);
        run(n);
        set_btn(which, 1'b0);
        bus.alarmset = 1'b0;
    endtask

    // Step the minute with time-set until it reads target (seconds stay frozen).
    task automatic set_min(input int target);
        bus.timeset = 1'b1;
        bus.minadv  = 1'b1;
        for (int i = 0; i < NS && int'(bus.tmin) != target; i++) run(1);
        bus.minadv  = 1'b0;
        bus.timeset = 1'b0;
        chk("set_min", 32'(bus.tmin), target);
    endtask

    task automatic wait_ring(input string name, input int limit);
        int n;
        n = 0;
        while (bus.ringing == '0 && n < limit) begin
            run(1);
            n++;
        end
        chk(name, 32'(bus.ringing != '0), 1);
    endtask

    task automatic count_while(input bit level, input int limit, output int n);
        n = 0;
        while ((bus.ringing != '0) == level && n < limit) begin
            n++;
            run(1);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        reset = 1'b1;
        bus.timeset = 1'b0; bus.alarmset = 1'b0; bus.alsel = '0;
        bus.minadv = 1'b0; bus.hrsadv = 1'b0; bus.dayadv = 1'b0;
        bus.alarmon = '0; bus.snooze = 1'b0; bus.ack = 1'b0;
        run(2);
        reset = 1'b0;
        chk("reset_tsec", 32'(bus.tsec), 0);
        chk("reset_buzz", 32'(bus.buzz), 0);

        // Wrap from day 6, 23:59:59.
        tpress(2, 6);
        tpress(1, 23);
        tpress(0, 58);
        run(119);
        chk("pre_wrap_day", 32'(bus.tdays), 6);
        chk("pre_wrap_hrs", 32'(bus.thrs), 23);
        chk("pre_wrap_min", 32'(bus.tmin), 59);
        chk("pre_wrap_sec", 32'(bus.tsec), 59);
        run(1);
        chk("wrap_time", {bus.tdays, bus.thrs, bus.tmin, bus.tsec}, 0);
        chk("wrap_buzz", 32'(bus.buzz), 0);

        // Every-day alarm on channel 1 at 00:02.
        do_reset();
        apress(1, 0, 2);
        apress(1, 2, 7);
        bus.alarmon = 2'b10;
        wait_ring("ed_ring_start", 300);
        chk("ed_ring_min", 32'(bus.tmin), 2);
        chk("ed_ring_sec", 32'(bus.tsec), 1);
        chk("ed_ring_vec", 32'(bus.ringing), 32'b10);
        count_while(1'b1, 1000, n);
        chk("ed_ring_len", n, RING_MAX);

        // Snooze on the 5th ringing cycle.
        set_min(1);
        wait_ring("snz_ring_start", 200);
        run(4);
        chk("snz_5th_high", 32'(bus.ringing), 32'b10);
        bus.snooze = 1'b1;
        run(1);
        bus.snooze = 1'b0;
        count_while(1'b0, 1000, n);
        chk("snz_low_len", n, SNZ_SEC);
        count_while(1'b1, 1000, n);
        chk("snz_rering_len", n, RING_MAX);

        // Ack while snoozed ends it for good.
        set_min(1);
        wait_ring("ack_ring_start", 200);
        run(2);
        bus.snooze = 1'b1;
        run(1);
        bus.snooze = 1'b0;
        run(10);
        bus.ack = 1'b1;
        run(1);
        bus.ack = 1'b0;
        count_while(1'b0, 400, n);
        chk("ack_no_ring", n, 400);

        // Day-specific alarm: day 3 set, try day 2 then day 3.
        apress(1, 2, 4);
        tpress(2, 2);
        set_min(1);
        count_while(1'b0, 150, n);
        chk("day_miss", n, 150);
        tpress(2, 1);
        set_min(1);
        wait_ring("day_hit", 200);
        chk("day_hit_day", 32'(bus.tdays), 3);
        bus.ack = 1'b1;
        run(1);
        bus.ack = 1'b0;
        chk("day_ack", 32'(bus.ringing), 0);

        // Manual set: 61 minute presses, no carry, seconds frozen.
        bus.alarmon = '0;
        do_reset();
        bus.timeset = 1'b1;
        bus.minadv  = 1'b1;
        run(61);
        bus.minadv  = 1'b0;
        chk("man_min", 32'(bus.tmin), 1);
        chk("man_hrs", 32'(bus.thrs), 0);
        chk("man_sec", 32'(bus.tsec), 0);
        // Channel 0 alarm (00:00 day 0) lined up while time-set is held.
        bus.alarmon = 2'b01;
        bus.minadv  = 1'b1;
        run(59);
        bus.minadv  = 1'b0;
        run(5);
        chk("man_suppress", 32'(bus.ringing), 0);
        bus.minadv  = 1'b1;
        run(1);
        bus.minadv  = 1'b0;
        bus.timeset = 1'b0;
        count_while(1'b0, 100, n);
        chk("man_not_deferred", n, 100);

        // Disarm while ringing, then reset plus snooze while ringing.
        bus.alarmon = '0;
        do_reset();
        apress(1, 0, 2);
        apress(1, 2, 7);
        bus.alarmon = 2'b10;
        wait_ring("dis_ring_start", 300);
        run(3);
        bus.alarmon = 2'b00;
        run(1);
        chk("disarm", 32'(bus.ringing), 0);
        bus.alarmon = 2'b10;
        set_min(1);
        wait_ring("rst_ring_start", 200);
        run(2);
        reset = 1'b1;
        bus.snooze = 1'b1;
        run(1);
        reset = 1'b0;
        bus.snooze = 1'b0;
        chk("rst_time", {bus.tdays, bus.thrs, bus.tmin, bus.tsec}, 0);
        chk("rst_ringing", 32'(bus.ringing), 0);
        chk("rst_buzz", 32'(bus.buzz), 0);
        bus.alarmset = 1'b1;
        bus.alsel = 1'b1;
        #1;
        chk("rst_alarm1", {bus.ddays, bus.dhrs, bus.dmin}, 0);
        bus.alsel = 1'b0;
        #1;
        chk("rst_alarm0", {bus.ddays, bus.dhrs, bus.dmin}, 0);
        bus.alarmset = 1'b0;
        bus.alarmon  = '0;

        // Random phase.
        do_reset();
        bus.alarmon = 2'b11;
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 999) < 2);
            if ($urandom_range(0, 63) == 0) bus.timeset  = ~bus.timeset;
            if ($urandom_range(0, 63) == 0) bus.alarmset = ~bus.alarmset;
            bus.alsel  = 1'($urandom_range(0, NA - 1));
            bus.minadv = ($urandom_range(0, 3) == 0);
            bus.hrsadv = ($urandom_range(0, 49) == 0);
            bus.dayadv = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) bus.alarmon = NA'($urandom_range(0, 3));
            bus.snooze = ($urandom_range(0, 79) == 0);
            bus.ack    = ($urandom_range(0, 599) == 0);
            run(1);
        end
        reset = 1'b0;
        bus.snooze = 1'b0;
        bus.ack = 1'b0;
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
